// File: rtl/spi_regfile.sv
// SPI-slave (mode 0) register bank oversampled in the clk domain.
// Command 0x01 = burst read, 0x02 = burst write, then address byte, then REG_W/8-byte words MSB first.
module spi_regfile #(
  parameter int REG_W       = 16,
  parameter int NUM_REGS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      spi_clk,
  input  logic                      spi_ss,
  input  logic                      spi_mosi,
  output logic                      spi_miso,
  output logic [NUM_REGS*REG_W-1:0] wr_regs,
  input  logic [NUM_REGS*REG_W-1:0] rd_regs,
  output logic [NUM_REGS-1:0]       wr_strobe,
  output logic                      busy,
  output logic                      frame_err
);

  localparam int NB = REG_W / 8;

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, DISCARD
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                   sclk_prev, ss_prev, armed;
  logic [2:0]             bit_cnt;
  logic [1:0]             byte_idx;
  logic [6:0]             in_byte;
  logic [7:0]             addr;
  logic [REG_W-1:0]       shreg, staging;

  logic                   sclk_s, ss_s, mosi_s;
  logic                   sclk_rise, sclk_fall, ss_rise, byte_done, last_byte;
  logic [7:0]             rx_byte, snap_addr;
  logic [REG_W-1:0]       rd_word, staging_next;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Nothing is decoded until ss has been seen high, so a frame cut by reset is never resumed.
  assign sclk_rise = armed & ~ss_s & sclk_s & ~sclk_prev;
  assign sclk_fall = armed & ~ss_s & ~sclk_s & sclk_prev;
  assign ss_rise   = armed & ss_s & ~ss_prev;
  assign byte_done = sclk_rise & (bit_cnt == 3'd7);
  assign rx_byte   = {in_byte, mosi_s};
  assign last_byte = (byte_idx == 2'(NB - 1));
  assign snap_addr = (state == RD_ADDR) ? rx_byte : addr + 8'd1;
  assign staging_next = (staging << 8) | REG_W'(rx_byte);

  // Addresses beyond the bank match no entry and read as zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (snap_addr == 8'(i)) rd_word = rd_regs[i*REG_W +: REG_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      ss_prev   <= 1'b0;
      armed     <= 1'b0;
      state     <= IDLE;
      bit_cnt   <= '0;
      byte_idx  <= '0;
      in_byte   <= '0;
      addr      <= '0;
      shreg     <= '0;
      staging   <= '0;
      spi_miso  <= 1'b0;
      wr_regs   <= '0;
      wr_strobe <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev <= sclk_s;
      ss_prev   <= ss_s;
      armed     <= armed | ss_s;
      busy      <= armed & ~ss_s;
      wr_strobe <= '0;
      frame_err <= 1'b0;

      if (ss_s) begin
        if (ss_rise)
          frame_err <= (bit_cnt != 3'd0) || (state == RD_ADDR) || (state == WR_ADDR) ||
                       ((state == WR_DATA) && (byte_idx != 2'd0));
        state    <= IDLE;
        bit_cnt  <= '0;
        byte_idx <= '0;
        shreg    <= '0;
        staging  <= '0;
        spi_miso <= 1'b0;
      end else begin
        if (sclk_fall) begin
          spi_miso <= shreg[REG_W-1];
          shreg    <= shreg << 1;
        end
        if (sclk_rise) begin
          in_byte <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (byte_done) begin
          case (state)
            IDLE: begin
              if (rx_byte == 8'h01)      state <= RD_ADDR;
              else if (rx_byte == 8'h02) state <= WR_ADDR;
              else                       state <= DISCARD;
            end
            RD_ADDR: begin
              addr     <= rx_byte;
              shreg    <= rd_word;
              byte_idx <= '0;
              state    <= RD_DATA;
            end
            RD_DATA: begin
              if (last_byte) begin
                byte_idx <= '0;
                addr     <= addr + 8'd1;
                shreg    <= rd_word;
              end else begin
                byte_idx <= byte_idx + 2'd1;
              end
            end
            WR_ADDR: begin
              addr     <= rx_byte;
              byte_idx <= '0;
              state    <= WR_DATA;
            end
            WR_DATA: begin
              if (last_byte) begin
                for (int i = 0; i < NUM_REGS; i++)
                  if (addr == 8'(i)) begin
                    wr_regs[i*REG_W +: REG_W] <= staging_next;
                    wr_strobe[i]              <= 1'b1;
                  end
                byte_idx <= '0;
                staging  <= '0;
                addr     <= addr + 8'd1;
              end else begin
                staging  <= staging_next;
                byte_idx <= byte_idx + 2'd1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
